// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one 2-way cache controller between two requesters,
// including its two-pass write-back/refill. Define ARB_STATS_EN for per-port miss counters.
module cache_port_arbiter #(
    parameter int TAG_W = 3,
    parameter int IDX_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0,
    input  logic             req1,
    input  logic             rw0,
    input  logic             rw1,
    input  logic [TAG_W-1:0] tag0,
    input  logic [TAG_W-1:0] tag1,
    input  logic [IDX_W-1:0] idx0,
    input  logic [IDX_W-1:0] idx1,
    output logic             ack0,
    output logic             ack1,
    output logic             miss0,
    output logic             miss1,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [TAG_W-1:0] cache_tag,
    output logic [IDX_W-1:0] cache_indice,
    output logic             cache_read_write,
    output logic             cache_en,
    input  logic             cache_hit_miss,
    input  logic             cache_writeback
`ifdef ARB_STATS_EN
   ,output logic [7:0]       miss_cnt0,
    output logic [7:0]       miss_cnt1
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WBACK, DONE} state_t;

    typedef struct packed {
        logic             rw;
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } req_t;

    state_t state;
    logic   ptr;
    req_t   op0, op1, cur;
    logic   pick1;
    logic   fin_miss;

    assign op0 = '{rw: rw0, tag: tag0, idx: idx0};
    assign op1 = '{rw: rw1, tag: tag1, idx: idx1};

    // Port 1 wins when alone, or when both ask and the pointer favours it.
    assign pick1 = req1 & (~req0 | ptr);

    // A refill pass always means the original access missed.
    assign fin_miss = (state == WBACK) | ~cache_hit_miss;

    assign cache_tag        = cur.tag;
    assign cache_indice     = cur.idx;
    assign cache_read_write = cur.rw;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            cur      <= '0;
            grant    <= 2'b00;
            busy     <= 1'b0;
            cache_en <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            miss0    <= 1'b0;
            miss1    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        cur      <= pick1 ? op1 : op0;
                        grant    <= pick1 ? 2'b10 : 2'b01;
                        busy     <= 1'b1;
                        cache_en <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE, WBACK: begin
                    // A writeback still flagged during WBACK is a protocol error; finish anyway.
                    if (state == ISSUE && cache_writeback) begin
                        state <= WBACK;
                    end else begin
                        if (grant[0]) miss0 <= fin_miss;
                        else          miss1 <= fin_miss;
                        ack0     <= grant[0];
                        ack1     <= grant[1];
                        cache_en <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= grant[0];
                    grant <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_STATS_EN
    // Saturating miss counters, bumped once per completed missing access.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            miss_cnt0 <= 8'd0;
            miss_cnt1 <= 8'd0;
        end else if (state == DONE) begin
            if (grant[0] && miss0 && miss_cnt0 != 8'hFF) miss_cnt0 <= miss_cnt0 + 8'd1;
            if (grant[1] && miss1 && miss_cnt1 != 8'hFF) miss_cnt1 <= miss_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter; the controller responses are driven by hand.
module tb_cache_port_arbiter;
    localparam int TAG_W = 3;
    localparam int IDX_W = 2;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             req0 = 0, req1 = 0, rw0 = 0, rw1 = 0;
    logic [TAG_W-1:0] tag0 = '0, tag1 = '0;
    logic [IDX_W-1:0] idx0 = '0, idx1 = '0;
    logic             ack0, ack1, miss0, miss1, busy, cache_read_write, cache_en;
    logic [1:0]       grant;
    logic [TAG_W-1:0] cache_tag;
    logic [IDX_W-1:0] cache_indice;
    logic             cache_hit_miss = 0, cache_writeback = 0;
`ifdef ARB_STATS_EN
    logic [7:0]       miss_cnt0, miss_cnt1;
`endif

    int passed = 0;
    int total  = 0;

    cache_port_arbiter #(.TAG_W(TAG_W), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .tag0(tag0), .tag1(tag1), .idx0(idx0), .idx1(idx1),
        .ack0(ack0), .ack1(ack1), .miss0(miss0), .miss1(miss1),
        .grant(grant), .busy(busy),
        .cache_tag(cache_tag), .cache_indice(cache_indice),
        .cache_read_write(cache_read_write), .cache_en(cache_en),
        .cache_hit_miss(cache_hit_miss), .cache_writeback(cache_writeback)
`ifdef ARB_STATS_EN
       ,.miss_cnt0(miss_cnt0), .miss_cnt1(miss_cnt1)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        total++;
        if ({ack0, ack1, miss0, miss1, grant, busy, cache_en, cache_read_write, cache_tag, cache_indice} !== 14'd0)
            $display("FAIL reset_outputs: got ack=%b%b miss=%b%b grant=%b busy=%b en=%b tag=%b idx=%b expected all 0",
                     ack1, ack0, miss1, miss0, grant, busy, cache_en, cache_tag, cache_indice);
        else passed++;
        @(negedge clock) reset_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp;
        @(negedge clock);
        req0 = 1; req1 = 1; rw0 = 0; tag0 = 3'd1; idx0 = 2'd0;
        rw1 = 1; tag1 = 3'd5; idx1 = 2'd3; cache_hit_miss = 1; cache_writeback = 0;
        for (int i = 0; i < 3; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            total++;
            if (grant !== exp || cache_tag !== (exp[0] ? 3'd1 : 3'd5))
                $display("FAIL sim_grant%0d: got grant=%b tag=%0d expected grant=%b tag=%0d",
                         i, grant, cache_tag, exp, exp[0] ? 1 : 5);
            else passed++;
            tick();
            total++;
            if ({ack1, ack0} !== exp)
                $display("FAIL sim_ack%0d: got ack1,ack0=%b expected %b", i, {ack1, ack0}, exp);
            else passed++;
            if (i == 2) begin
                @(negedge clock);
                req0 = 0; req1 = 0;
            end
            tick();
            total++;
            if ({ack1, ack0} !== 2'b00 || grant !== 2'b00)
                $display("FAIL sim_done%0d: got ack=%b grant=%b expected ack=00 grant=00", i, {ack1, ack0}, grant);
            else passed++;
        end
    endtask

    task automatic test_read_hit();
        @(negedge clock);
        req0 = 1; rw0 = 0; tag0 = 3'b000; idx0 = 2'b01; cache_hit_miss = 1; cache_writeback = 0;
        tick();
        total++;
        if (grant !== 2'b01 || cache_tag !== 3'b000 || cache_indice !== 2'b01 || cache_read_write !== 1'b0)
            $display("FAIL hit_issue: got grant=%b tag=%b idx=%b rw=%b expected 01 000 01 0",
                     grant, cache_tag, cache_indice, cache_read_write);
        else passed++;
        total++;
        if (cache_en !== 1'b1 || ack0 !== 1'b0)
            $display("FAIL hit_en: got en=%b ack0=%b expected en=1 ack0=0", cache_en, ack0);
        else passed++;
        tick();
        total++;
        if (ack0 !== 1'b1 || miss0 !== 1'b0 || cache_en !== 1'b0)
            $display("FAIL hit_ack: got ack0=%b miss0=%b en=%b expected 1 0 0", ack0, miss0, cache_en);
        else passed++;
        @(negedge clock) req0 = 0;
        tick();
        total++;
        if (ack0 !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || cache_tag !== 3'b000 || cache_indice !== 2'b01)
            $display("FAIL hit_done: got ack0=%b grant=%b busy=%b tag=%b idx=%b expected 0 00 0 000 01",
                     ack0, grant, busy, cache_tag, cache_indice);
        else passed++;
    endtask

    task automatic test_read_miss();
        @(negedge clock);
        req0 = 1; rw0 = 0; tag0 = 3'd6; idx0 = 2'd3; cache_hit_miss = 0; cache_writeback = 0;
        tick();
        tick();
        total++;
        if (ack0 !== 1'b1 || miss0 !== 1'b1 || miss1 !== 1'b0)
            $display("FAIL rmiss_ack: got ack0=%b miss0=%b miss1=%b expected 1 1 0", ack0, miss0, miss1);
        else passed++;
        @(negedge clock) req0 = 0;
        tick();
    endtask

    task automatic test_writeback();
        @(negedge clock);
        req1 = 1; rw1 = 1; tag1 = 3'b010; idx1 = 2'b10; cache_hit_miss = 0; cache_writeback = 1;
        tick();
        total++;
        if (grant !== 2'b10 || cache_tag !== 3'b010 || cache_indice !== 2'b10 || cache_read_write !== 1'b1 || cache_en !== 1'b1)
            $display("FAIL wb_issue: got grant=%b tag=%b idx=%b rw=%b en=%b expected 10 010 10 1 1",
                     grant, cache_tag, cache_indice, cache_read_write, cache_en);
        else passed++;
        // writeback left asserted and hit reported during refill: must still finish as a miss
        @(negedge clock) cache_hit_miss = 1;
        tick();
        total++;
        if (ack1 !== 1'b0 || cache_en !== 1'b1 || busy !== 1'b1)
            $display("FAIL wb_pass2: got ack1=%b en=%b busy=%b expected 0 1 1", ack1, cache_en, busy);
        else passed++;
        tick();
        total++;
        if (ack1 !== 1'b1 || miss1 !== 1'b1 || cache_en !== 1'b0 || miss0 !== 1'b1)
            $display("FAIL wb_ack: got ack1=%b miss1=%b en=%b miss0=%b expected 1 1 0 1",
                     ack1, miss1, cache_en, miss0);
        else passed++;
        @(negedge clock);
        req1 = 0; cache_writeback = 0;
        tick();
        total++;
        if (ack1 !== 1'b0 || grant !== 2'b00)
            $display("FAIL wb_done: got ack1=%b grant=%b expected 0 00", ack1, grant);
        else passed++;
    endtask

    task automatic test_reset_wback();
        // finish a port-0 access first so the pointer favours port 1 before reset
        @(negedge clock);
        req0 = 1; rw0 = 0; tag0 = 3'd7; cache_hit_miss = 1; cache_writeback = 0;
        tick();
        tick();
        @(negedge clock) req0 = 0;
        tick();
        @(negedge clock);
        req0 = 1; rw0 = 1; cache_writeback = 1;
        tick();
        tick();
        total++;
        if (cache_en !== 1'b1 || ack0 !== 1'b0)
            $display("FAIL rst_wback_pre: got en=%b ack0=%b expected 1 0", cache_en, ack0);
        else passed++;
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({ack0, ack1, miss0, miss1, grant, busy, cache_en, cache_read_write, cache_tag, cache_indice} !== 14'd0)
            $display("FAIL rst_wback_async: got ack=%b%b miss=%b%b grant=%b busy=%b en=%b tag=%b expected all 0",
                     ack1, ack0, miss1, miss0, grant, busy, cache_en, cache_tag);
        else passed++;
        @(negedge clock);
        reset_n = 1'b1; req0 = 0; cache_writeback = 0;
        tick();
        total++;
        if (ack0 !== 1'b0 || grant !== 2'b00)
            $display("FAIL rst_wback_noack: got ack0=%b grant=%b expected 0 00", ack0, grant);
        else passed++;
        @(negedge clock);
        req0 = 1; req1 = 1; rw0 = 0; cache_hit_miss = 1;
        tick();
        total++;
        if (grant !== 2'b01)
            $display("FAIL rst_ptr: got grant=%b expected 01", grant);
        else passed++;
        tick();
        @(negedge clock);
        req0 = 0; req1 = 0;
        tick();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        @(negedge clock);
        req0 = 1; rw0 = 0; cache_hit_miss = 0; cache_writeback = 0;
        for (int i = 0; i < 260; i++) begin
            tick();
            tick();
            if (i == 259) begin
                @(negedge clock);
                req0 = 0;
            end
            tick();
            if (i == 9) begin
                total++;
                if (miss_cnt0 !== 8'd10)
                    $display("FAIL stats_mid: got miss_cnt0=%0d expected 10", miss_cnt0);
                else passed++;
            end
        end
        total++;
        if (miss_cnt0 !== 8'd255 || miss_cnt1 !== 8'd0)
            $display("FAIL stats_sat: got cnt0=%0d cnt1=%0d expected 255 0", miss_cnt0, miss_cnt1);
        else passed++;
        @(negedge clock) req1 = 1;
        tick();
        tick();
        @(negedge clock) req1 = 0;
        tick();
        total++;
        if (miss_cnt0 !== 8'd255 || miss_cnt1 !== 8'd1)
            $display("FAIL stats_port1: got cnt0=%0d cnt1=%0d expected 255 1", miss_cnt0, miss_cnt1);
        else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_simultaneous();
        test_read_hit();
        test_read_miss();
        test_writeback();
        test_reset_wback();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

- Shares the 2-way cache controller between two requesters (req 0 and req 1) and sequences each access through it.
- Handles the controller's two-pass write-back/refill: the grant is held until the refill pass completes, then a one-cycle ack and a miss flag are returned to the winning requester.
- Arbitration is round-robin.
- Sits between the requester ports and the cache controller's tag/indice/read_write inputs.

## Interface
- TAG_W, 3, tag width (matches controller tag).
- IDX_W, 2, set index width (matches controller indice).
- clock  in  1  system clock. Arbiter logic is posedge; the controller samples on negedge.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; held high until the matching ack.
- rw0 / rw1  in  1  1 = write, 0 = read.
- tag0 / tag1  in  TAG_W  access tag.
- idx0 / idx1  in  IDX_W  access set index.
- ack0 / ack1  out  1  one-cycle completion pulse.
- miss0 / miss1  out  1  result of the last completed access: 1 = miss. Valid with ack; held until that port's next ack.
- grant  out  2  one-hot owner of the controller; 00 when idle.
- busy  out  1  high in ISSUE, WBACK and DONE.
- cache_tag  out  TAG_W  to controller tag.
- cache_indice  out  IDX_W  to controller indice.
- cache_read_write  out  1  to controller read_write.
- cache_en  out  1  high only in ISSUE and WBACK. The integration wrapper gates the controller's clock with it, so the controller evaluates exactly once per arbiter pass.
- cache_hit_miss  in  1  from controller hit_miss.
- cache_writeback  in  1  from controller writeback.

## Operation
- **FSM states:** IDLE, ISSUE, WBACK, DONE.
- **IDLE:**
  - No request: stay in IDLE.
  - Exactly one request: that requester wins.
  - Both requesting: the winner is given by the priority pointer `ptr` (0 or 1).
  - On a win: register the winner's tag/idx/rw into the cache_* outputs, set grant, go to ISSUE.
- **ISSUE:** the controller evaluates at the negedge inside this cycle. At the next posedge:
  - cache_writeback = 1: go to WBACK. No ack.
  - Otherwise: latch miss = ~cache_hit_miss, go to DONE.
  - A read miss into an invalid way (hit_miss = 0, no writeback) completes here with miss = 1.
- **WBACK:** the controller performs the refill pass at the negedge. At the next posedge:
  - latch miss = 1, regardless of cache_hit_miss;
  - go to DONE.
  - cache_writeback still being 1 here is a protocol error: treat it as done, do not loop.
- **DONE:**
  - ack of the granted port = 1 for this cycle;
  - `ptr` ← index of the other requester;
  - grant ← 00;
  - go to IDLE.
- **Operand stability:** cache_tag, cache_indice and cache_read_write hold stable from grant until the next grant. Requester inputs are ignored after the IDLE sample.
- **Request still high after ack:** a requester keeping req high after its ack is treated as a new request in IDLE. The moved pointer favours the other requester if both are high.
- **Reset values:** all outputs 0, FSM = IDLE, ptr = 0, miss0/miss1 = 0. Reset asserted mid-transaction (ISSUE or WBACK) aborts immediately: no ack, cache_en drops asynchronously.

## Timing
- Edge E0: IDLE samples the request; grant and cache_* are valid after E0.
- Hit, or no-writeback miss: ack is high E1→E2. Ack comes 1 cycle after the grant.
- Writeback path: ack is high E2→E3. Ack comes 2 cycles after the grant.
- DONE → IDLE takes one cycle. Minimum spacing between grants is 3 cycles (hit path) or 4 cycles (writeback path).
- cache_en is high for exactly 1 cycle (hit path) or 2 cycles (writeback path) per transaction.
- Worst-case wait for a requester is one full transaction of the other port (4 cycles), then its own grant.

## Configuration
- **ARB_STATS_EN defined:**
  - Adds outputs miss_cnt0 and miss_cnt1 [7:0].
  - The port's counter increments in DONE when that port's miss = 1.
  - Counters saturate at 255.
  - Reset to 0 by reset_n.
- **ARB_STATS_EN undefined:** the ports and counters are absent. All other behaviour is identical.

## Test plan
- **Reset:** assert reset_n = 0 mid-run → all outputs 0 and grant = 00. After release, req0 is granted first on a simultaneous request (ptr = 0).
- **req0 read hit:** req0 = 1, rw0 = 0, tag0 = 3'b000, idx0 = 2'b01, controller returns hit_miss = 1, writeback = 0 → cache_tag = 000 and cache_indice = 01 after E0; ack0 pulse E1→E2 with miss0 = 0; cache_en high 1 cycle.
- **Simultaneous requests:** req0 and req1 both held high → grants alternate 01, 10, 01; each ack is one cycle; ack0 and ack1 are never high together.
- **Write miss with write-back:** req1 write, tag 3'b010, idx 2'b10, controller writeback = 1 at the ISSUE sample → state goes to WBACK; cache_en high 2 cycles; ack1 pulse E2→E3 with miss1 = 1.
- **Reset during WBACK:** reset_n pulsed low in WBACK → no ack issued; FSM returns to IDLE; cache_en = 0 immediately.
- **Statistics (ARB_STATS_EN):** 260 consecutive misses on port 0 → miss_cnt0 = 255 and holds; miss_cnt1 = 0.
